// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one single-port SRAM between a buffered SPI write path
//               and REQUESTER_COUNT round-robin read requesters (LED output
//               channels). Writes take priority over reads; a read in flight
//               is never preempted.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   write_address/_data    : SPI write word, qualified by write_strobe
//   write_strobe           : single-cycle write pulse
//   read_requests          : per-requester level request, held until served
//   read_addresses         : flattened addresses, requester i at [i*AW +: AW]
//   read_data              : shared read result, valid while a strobe is high
//   read_finished_strobes  : per-requester one-cycle completion pulse
//   mem_address/_wdata/_we : SRAM command, mem_rdata : SRAM read data
//   write_overflow         : sticky flag, a write was dropped
//   state                  : current FSM state (debug)
//
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int REQUESTER_COUNT   = 3,
    parameter int READ_LATENCY      = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0]                 write_address,
    input  logic [DATA_BUS_WIDTH-1:0]                    write_data,
    input  logic                                         write_strobe,
    input  logic [REQUESTER_COUNT-1:0]                   read_requests,
    input  logic [REQUESTER_COUNT*ADDRESS_BUS_WIDTH-1:0] read_addresses,
    output logic [DATA_BUS_WIDTH-1:0]                    read_data,
    output logic [REQUESTER_COUNT-1:0]                   read_finished_strobes,
    output logic [ADDRESS_BUS_WIDTH-1:0]                 mem_address,
    output logic [DATA_BUS_WIDTH-1:0]                    mem_wdata,
    output logic                                         mem_we,
    input  logic [DATA_BUS_WIDTH-1:0]                    mem_rdata,
    output logic                                         write_overflow,
    output logic [1:0]                                   state
);

    localparam int c_GW = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_READ  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [1:0]      c_LAT_LAST  = 2'(READ_LATENCY - 1);
    localparam logic [c_GW-1:0] c_LAST_IDX  = c_GW'(REQUESTER_COUNT - 1);

    logic [1:0]                   r_state;
    logic [1:0]                   w_next_state;

    // One-deep write buffer
    logic [ADDRESS_BUS_WIDTH-1:0] r_wbuf_addr;
    logic [DATA_BUS_WIDTH-1:0]    r_wbuf_data;
    logic                         r_wbuf_valid;
    logic                         r_overflow;
    logic                         w_draining;

    // Arbitration
    logic [c_GW-1:0]              r_last_grant;
    logic [c_GW-1:0]              r_grant;
    logic                         r_mask_last;
    logic [REQUESTER_COUNT-1:0]   w_last_onehot;
    logic [REQUESTER_COUNT-1:0]   w_grant_onehot;
    logic [REQUESTER_COUNT-1:0]   w_req_masked;
    logic [2*REQUESTER_COUNT-1:0] w_req_rot;
    logic [c_GW-1:0]              w_shift;
    logic                         w_any;
    logic [c_GW-1:0]              w_grant_idx;
    int                           w_sum;
    logic [c_GW-1:0]              w_rd_idx;
    logic [ADDRESS_BUS_WIDTH-1:0] w_rd_addr;

    // Datapath / output registers
    logic [1:0]                   r_lat_cnt;
    logic [ADDRESS_BUS_WIDTH-1:0] r_mem_address;
    logic [DATA_BUS_WIDTH-1:0]    r_mem_wdata;
    logic                         r_mem_we;
    logic [DATA_BUS_WIDTH-1:0]    r_read_data;
    logic [REQUESTER_COUNT-1:0]   r_strobes;

    assign w_draining = (r_state == c_ST_WRITE);

    // ------------------------------------------------------------------------
    // Round-robin search. The request vector is duplicated and shifted so the
    // lowest set bit of the window is the first requester after last_grant.
    // The requester just served is masked for one IDLE cycle so a requester
    // that drops its request in response to its strobe is not served twice.
    // ------------------------------------------------------------------------
    always_comb begin
        w_last_onehot  = '0;
        w_grant_onehot = '0;
        w_rd_addr      = '0;
        w_any          = 1'b0;
        w_grant_idx    = '0;
        w_sum          = 0;
        w_shift        = (r_last_grant == c_LAST_IDX) ? '0 : r_last_grant + c_GW'(1);

        for (int j = 0; j < REQUESTER_COUNT; j++) begin
            w_last_onehot[j] = (r_last_grant == c_GW'(j));
        end

        w_req_masked = read_requests & ~(r_mask_last ? w_last_onehot : '0);
        w_req_rot    = {w_req_masked, w_req_masked} >> w_shift;

        for (int j = 0; j < REQUESTER_COUNT; j++) begin
            if (!w_any && w_req_rot[j]) begin
                w_any = 1'b1;
                w_sum = int'(w_shift) + j;
                if (w_sum >= REQUESTER_COUNT) begin
                    w_sum = w_sum - REQUESTER_COUNT;
                end
                w_grant_idx = c_GW'(w_sum);
            end
        end

        // The granted index is still combinational in the grant cycle
        w_rd_idx = (r_state == c_ST_IDLE) ? w_grant_idx : r_grant;

        for (int j = 0; j < REQUESTER_COUNT; j++) begin
            if (w_rd_idx == c_GW'(j)) begin
                w_rd_addr = read_addresses[j*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
            end
            w_grant_onehot[j] = (r_grant == c_GW'(j));
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_wbuf_valid) begin
                    w_next_state = c_ST_WRITE;
                end else if (w_any) begin
                    w_next_state = c_ST_READ;
                end
            end
            c_ST_WRITE: w_next_state = c_ST_IDLE;
            c_ST_READ: begin
                if (r_lat_cnt == c_LAT_LAST) begin
                    w_next_state = c_ST_DONE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Write buffer. A strobe in the drain cycle refills the buffer instead of
    // overflowing it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbuf_addr  <= '0;
            r_wbuf_data  <= '0;
            r_wbuf_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (write_strobe) begin
            if (!r_wbuf_valid || w_draining) begin
                r_wbuf_addr  <= write_address;
                r_wbuf_data  <= write_data;
                r_wbuf_valid <= 1'b1;
            end else begin
                r_overflow   <= 1'b1;
            end
        end else if (w_draining) begin
            r_wbuf_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // SRAM command and read-result registers, loaded from the next state so
    // the command is valid for the whole WRITE / READ state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_read_data   <= '0;
            r_strobes     <= '0;
            r_last_grant  <= c_LAST_IDX;
            r_grant       <= '0;
            r_lat_cnt     <= '0;
            r_mask_last   <= 1'b0;
        end else begin
            r_mem_we    <= (w_next_state == c_ST_WRITE);
            r_strobes   <= '0;
            r_mask_last <= (r_state == c_ST_DONE);

            if (w_next_state == c_ST_WRITE) begin
                r_mem_address <= r_wbuf_addr;
                r_mem_wdata   <= r_wbuf_data;
            end else if (w_next_state == c_ST_READ) begin
                r_mem_address <= w_rd_addr;
            end

            if (r_state == c_ST_IDLE && w_next_state == c_ST_READ) begin
                r_grant   <= w_grant_idx;
                r_lat_cnt <= '0;
            end else if (r_state == c_ST_READ) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end

            if (r_state == c_ST_READ && w_next_state == c_ST_DONE) begin
                r_read_data  <= mem_rdata;
                r_strobes    <= w_grant_onehot;
                r_last_grant <= r_grant;
            end
        end
    end

    assign read_data             = r_read_data;
    assign read_finished_strobes = r_strobes;
    assign mem_address           = r_mem_address;
    assign mem_wdata             = r_mem_wdata;
    assign mem_we                = r_mem_we;
    assign write_overflow        = r_overflow;
    assign state                 = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Directed self-checking bench for sram_port_arbiter. One
//               instance with READ_LATENCY=1, one with READ_LATENCY=4. The
//               SRAM model returns address + 0x1134.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [15:0] wa, wd, rd, ma, mwd, mrd;
    logic        ws, mwe, ovf;
    logic [2:0]  req, fin;
    logic [47:0] ra;
    logic [1:0]  st;

    logic [15:0] wa4, wd4, rd4, ma4, mwd4, mrd4;
    logic        ws4, mwe4, ovf4;
    logic [2:0]  req4, fin4;
    logic [47:0] ra4;
    logic [1:0]  st4;

    assign mrd  = ma  + 16'h1134;
    assign mrd4 = ma4 + 16'h1134;

    sram_port_arbiter #(
        .ADDRESS_BUS_WIDTH(16), .DATA_BUS_WIDTH(16),
        .REQUESTER_COUNT(3),    .READ_LATENCY(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .write_address(wa), .write_data(wd), .write_strobe(ws),
        .read_requests(req), .read_addresses(ra),
        .read_data(rd), .read_finished_strobes(fin),
        .mem_address(ma), .mem_wdata(mwd), .mem_we(mwe), .mem_rdata(mrd),
        .write_overflow(ovf), .state(st)
    );

    sram_port_arbiter #(
        .ADDRESS_BUS_WIDTH(16), .DATA_BUS_WIDTH(16),
        .REQUESTER_COUNT(3),    .READ_LATENCY(4)
    ) u_dut4 (
        .clk(clk), .rst(rst),
        .write_address(wa4), .write_data(wd4), .write_strobe(ws4),
        .read_requests(req4), .read_addresses(ra4),
        .read_data(rd4), .read_finished_strobes(fin4),
        .mem_address(ma4), .mem_wdata(mwd4), .mem_we(mwe4), .mem_rdata(mrd4),
        .write_overflow(ovf4), .state(st4)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ws = 1'b0; wa = '0; wd = '0; req = '0; ra = '0;
        ws4 = 1'b0; wa4 = '0; wd4 = '0; req4 = '0; ra4 = '0;
        step(); step();

        // Reset state
        check("rst_state", st, 0);
        check("rst_we", mwe, 0);
        check("rst_addr", ma, 0);
        check("rst_wdata", mwd, 0);
        check("rst_rdata", rd, 0);
        check("rst_fin", fin, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state4", st4, 0);
        rst = 1'b0;
        step();

        // Single write: mem_we two cycles after the strobe, for one cycle
        ws = 1'b1; wa = 16'h0010; wd = 16'hBEEF;
        step(); ws = 1'b0;
        check("wr_wait_state", st, 0);
        check("wr_wait_we", mwe, 0);
        step();
        check("wr_we", mwe, 1);
        check("wr_addr", ma, 16'h0010);
        check("wr_data", mwd, 16'hBEEF);
        check("wr_state", st, 1);
        step();
        check("wr_end_we", mwe, 0);
        check("wr_end_state", st, 0);

        // Read for requester 1, result two cycles after grant
        ra[31:16] = 16'h0100; req = 3'b010;
        step();
        check("rd_state", st, 2);
        check("rd_addr", ma, 16'h0100);
        check("rd_we", mwe, 0);
        check("rd_fin0", fin, 0);
        step();
        check("rd_done_state", st, 3);
        check("rd_fin", fin, 3'b010);
        check("rd_data", rd, 16'h1234);
        step();  // request still high here, must be masked
        check("rd_idle_state", st, 0);
        check("rd_fin_clr", fin, 0);
        check("rd_hold", rd, 16'h1234);
        step();
        check("rd_mask", st, 0);
        req = 3'b000;
        step();

        // Round robin, all requesters held from reset
        rst = 1'b1; ra = {16'h0400, 16'h0300, 16'h0200}; req = 3'b111;
        step(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_read", st, 2);
            check("rr_fin_read", fin, 0);
            step();
            check("rr_fin", fin, 3'b001 << (i % 3));
            check("rr_data", rd, 16'h1334 + 16'h0100 * (i % 3));
            step();
            check("rr_fin_idle", fin, 0);
        end
        req = 3'b000;

        // Write during a read of requester 0: read finishes, then write
        req = 3'b001;
        step();
        check("wdr_state", st, 2);
        ws = 1'b1; wa = 16'h0020; wd = 16'hCAFE;
        step(); ws = 1'b0;
        check("wdr_fin", fin, 3'b001);
        check("wdr_done_we", mwe, 0);
        req = 3'b000;
        step();
        check("wdr_idle", st, 0);
        step();
        check("wdr_we", mwe, 1);
        check("wdr_addr", ma, 16'h0020);
        check("wdr_data", mwd, 16'hCAFE);
        check("wdr_ovf", ovf, 0);
        step();

        // Overflow with READ_LATENCY=1: strobes in READ and DONE
        req = 3'b010;
        step();
        ws = 1'b1; wa = 16'h0030; wd = 16'h1111;
        step();
        wa = 16'h0040; wd = 16'h2222;
        check("ov_fin", fin, 3'b010);
        check("ov_data", rd, 16'h1434);
        req = 3'b000;
        step(); ws = 1'b0;
        check("ov_flag", ovf, 1);
        step();
        check("ov_wr_addr", ma, 16'h0030);
        check("ov_wr_data", mwd, 16'h1111);
        step(); step();
        check("ov_sticky", ovf, 1);
        check("ov_state", st, 0);

        // Overflow with READ_LATENCY=4
        ra4[15:0] = 16'h0500; req4 = 3'b001;
        step();
        ws4 = 1'b1; wa4 = 16'h0050; wd4 = 16'h3333;
        step();
        wa4 = 16'h0060; wd4 = 16'h4444;
        step(); ws4 = 1'b0;
        check("l4_state3", st4, 2);
        check("l4_ovf", ovf4, 1);
        step();
        check("l4_state4", st4, 2);
        check("l4_fin0", fin4, 0);
        step();
        check("l4_done", st4, 3);
        check("l4_fin", fin4, 3'b001);
        check("l4_data", rd4, 16'h1634);
        req4 = 3'b000;
        step(); step();
        check("l4_we", mwe4, 1);
        check("l4_addr", ma4, 16'h0050);
        step();
        check("l4_sticky", ovf4, 1);

        // Reset during READ aborts; write coincident with reset is ignored
        req = 3'b100;
        step();
        check("ab_read", st, 2);
        rst = 1'b1; ws = 1'b1; wa = 16'h0070; wd = 16'h5555; req = 3'b101;
        step();
        check("ab_state", st, 0);
        check("ab_fin", fin, 0);
        check("ab_we", mwe, 0);
        check("ab_ovf", ovf, 0);
        check("ab_ovf4", ovf4, 0);
        rst = 1'b0; ws = 1'b0;
        step();
        check("ab_grant_state", st, 2);
        check("ab_grant_we", mwe, 0);
        check("ab_grant_addr", ma, 16'h0200);
        step();
        check("ab_grant_fin", fin, 3'b001);
        req = 3'b000;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
